// File: rtl/gray_pkg.sv
// -----------------------------------------------------------------------------
// gray_pkg
// Shared Gray-code helpers for the binary-to-Gray counter, its step checker,
// and the companion Gray-to-binary decoder.
//   GRAY_WIDTH_DEF     : default counter / code width
//   GRAY_MAX_W         : widest code the helpers handle; callers zero-extend
//   bin2gray()         : binary -> Gray, gray = bin ^ (bin >> 1)
//   gray_popcount_diff : number of bit positions in which two codes differ
// -----------------------------------------------------------------------------
package gray_pkg;

  localparam int GRAY_WIDTH_DEF = 8;
  localparam int GRAY_MAX_W     = 32;

  // Zero-extension of a narrower operand is harmless: the top code bit sees a
  // zero neighbour and therefore equals the MSB, as the encoding requires.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 5'd1);
  endfunction

  function automatic logic [7:0] gray_popcount_diff(input logic [GRAY_MAX_W-1:0] a,
                                                    input logic [GRAY_MAX_W-1:0] b);
    logic [GRAY_MAX_W-1:0] x;
    logic [7:0]            cnt;
    x   = a ^ b;
    cnt = 8'd0;
    for (int i = 0; i < GRAY_MAX_W; i++) begin
      cnt = cnt + {7'd0, x[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/gray_step_checker.sv
// -----------------------------------------------------------------------------
// gray_step_checker
// Flags any step of a Gray sequence that does not change exactly one bit.
// The flag is sticky until rst.
//   clk         in  : rising-edge clock
//   rst         in  : synchronous active-high reset, clears err
//   check_valid in  : prev_gray/curr_gray form a step to be checked this cycle
//   prev_gray   in  : code before the step
//   curr_gray   in  : code after the step
//   err         out : sticky step-error flag (registered)
// -----------------------------------------------------------------------------
module gray_step_checker
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             check_valid,
  input  logic [WIDTH-1:0] prev_gray,
  input  logic [WIDTH-1:0] curr_gray,
  output logic             err
);

  logic [7:0] diff_s;
  logic       err_q;
  logic       err_d;

  // Count differing bits between the two codes and decide the next flag value.
  always_comb begin
    diff_s = gray_popcount_diff(GRAY_MAX_W'(prev_gray), GRAY_MAX_W'(curr_gray));
    if (check_valid && (diff_s != 8'd1)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Sticky error register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: rtl/binary_to_gray_counter.sv
// -----------------------------------------------------------------------------
// binary_to_gray_counter
// Registered binary counter that also publishes its count as Gray code. The
// Gray register is loaded from the encoding of the *next* binary value, so the
// two outputs are aligned and gray_value changes glitch-free, one bit per step.
//   clk          in  : rising-edge clock
//   rst          in  : synchronous active-high reset
//   en           in  : advance count by one
//   load         in  : load counter from load_value (priority over en)
//   load_value   in  : binary value to load
//   binary_value out : registered binary count
//   gray_value   out : registered Gray code of binary_value
//   wrap         out : one-cycle pulse when the count advances all-ones -> 0
//   err          out : sticky Gray-step error flag
// Optional feature: define GRAY_CNT_STEP_CHK_EN to build the step checker;
// otherwise err is tied low. The port list is the same in both builds.
// -----------------------------------------------------------------------------
module binary_to_gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] binary_value,
  output logic [WIDTH-1:0] gray_value,
  output logic             wrap,
  output logic             err
);

  logic [WIDTH-1:0]      bin_q;
  logic [WIDTH-1:0]      bin_d;
  logic [WIDTH-1:0]      gray_q;
  logic [WIDTH-1:0]      gray_d;
  logic                  wrap_q;
  logic                  wrap_d;
  logic [GRAY_MAX_W-1:0] gray_ext_s;
  logic                  gray_unused_s;

  // Next-state selection: load beats en, otherwise hold; Gray follows bin_d.
  always_comb begin
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_value;
    end else if (en) begin
      bin_d  = bin_q + {{(WIDTH-1){1'b0}}, 1'b1};
      wrap_d = (bin_q == {WIDTH{1'b1}});
    end else begin
      bin_d = bin_q;
    end
    gray_ext_s = bin2gray(GRAY_MAX_W'(bin_d));
    gray_d     = gray_ext_s[WIDTH-1:0];
  end

  // Only the low WIDTH bits of the widened encoding are meaningful.
  assign gray_unused_s = ^gray_ext_s;

  // Binary, Gray and wrap registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= {WIDTH{1'b0}};
      gray_q <= {WIDTH{1'b0}};
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign binary_value = bin_q;
  assign gray_value   = gray_q;
  assign wrap         = wrap_q;

`ifdef GRAY_CNT_STEP_CHK_EN
  logic             chk_valid_q;
  logic [WIDTH-1:0] prev_gray_q;

  // Remember the code before each en-only advance; the checker compares it
  // with the new gray_value one cycle later. Loads and reset clear the valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_valid_q <= 1'b0;
      prev_gray_q <= {WIDTH{1'b0}};
    end else if (en && !load) begin
      chk_valid_q <= 1'b1;
      prev_gray_q <= gray_q;
    end else begin
      chk_valid_q <= 1'b0;
      prev_gray_q <= prev_gray_q;
    end
  end

  gray_step_checker #(
    .WIDTH (WIDTH)
  ) u_step_checker (
    .clk         (clk),
    .rst         (rst),
    .check_valid (chk_valid_q),
    .prev_gray   (prev_gray_q),
    .curr_gray   (gray_q),
    .err         (err)
  );
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_binary_to_gray_counter.sv
module tb_binary_to_gray_counter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         load;
  logic [W-1:0] load_value;
  logic [W-1:0] binary_value;
  logic [W-1:0] gray_value;
  logic         wrap;
  logic         err;

  int n_check = 0;
  int n_pass  = 0;

  // reference model state (plain arithmetic)
  int m_bin  = 0;
  int m_wrap = 0;
  int m_err  = 0;

  binary_to_gray_counter #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .load         (load),
    .load_value   (load_value),
    .binary_value (binary_value),
    .gray_value   (gray_value),
    .wrap         (wrap),
    .err          (err)
  );

  always #5 clk = ~clk;

  function automatic int enc(input int b);
    return b ^ (b / 2);
  endfunction

  // decoder reference: binary = XOR of all right shifts of the code
  function automatic int dec(input int g);
    int b;
    b = 0;
    for (int s = 0; s < W; s++) b = b ^ (g >> s);
    return b % (1 << W);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_check = n_check + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_bin"},  int'(binary_value), m_bin);
    chk({tag, "_gray"}, int'(gray_value),   enc(m_bin));
    chk({tag, "_wrap"}, int'(wrap),         m_wrap);
    chk({tag, "_err"},  int'(err),          m_err);
  endtask

  task automatic tick();
    if (rst) begin
      m_bin = 0; m_wrap = 0; m_err = 0;
    end else if (load) begin
      m_bin = int'(load_value); m_wrap = 0;
    end else if (en) begin
      m_wrap = (m_bin == (1 << W) - 1) ? 1 : 0;
      m_bin  = (m_bin + 1) % (1 << W);
    end else begin
      m_wrap = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_seq [6];
    int prev_g;
    int wraps;
    exp_seq = '{8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05};

    // reset held with en=1
    rst = 1'b1; en = 1'b1; load = 1'b0; load_value = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick(); check_all("reset");
    end

    // count 6 steps
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(); check_all("count");
      chk("count_seq", int'(gray_value), exp_seq[i]);
    end

    // load FE then wrap through FF -> 00
    en = 1'b0; load = 1'b1; load_value = 8'hFE;
    tick(); check_all("load_fe"); chk("load_fe_const", int'(gray_value), 8'h81);
    load = 1'b0; en = 1'b1;
    tick(); check_all("to_ff"); chk("to_ff_const", int'(gray_value), 8'h80);
    tick(); check_all("wrap"); chk("wrap_const", int'(wrap), 1);
    en = 1'b0;
    tick(); check_all("wrap_end"); chk("wrap_pulse_one", int'(wrap), 0);

    // load beats en, then hold
    load = 1'b1; en = 1'b1; load_value = 8'h10;
    tick(); check_all("prio"); chk("prio_const", int'(gray_value), 8'h18);
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); check_all("hold");
    end

    // loading the current value changes nothing
    load = 1'b1; load_value = binary_value;
    tick(); check_all("load_same"); chk("load_same_const", int'(binary_value), 8'h10);
    load = 1'b0;

    // full sweep from 00
    load = 1'b1; load_value = 8'h00;
    tick(); check_all("sweep_start");
    load = 1'b0; en = 1'b1;
    wraps = 0;
    for (int i = 0; i < (1 << W); i++) begin
      prev_g = int'(gray_value);
      tick(); check_all("sweep");
      chk("sweep_1bit", $countones(prev_g ^ int'(gray_value)), 1);
      chk("sweep_dec", dec(int'(gray_value)), int'(binary_value));
      if (wrap) wraps = wraps + 1;
    end
    chk("sweep_wraps", wraps, 1);
    chk("sweep_final", int'(binary_value), 0);

    // randomized mix against the model
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(31) == 0);
      load       = ($urandom_range(7) == 0);
      en         = ($urandom_range(3) != 0);
      load_value = W'($urandom);
      tick(); check_all("rand");
    end

    // reset mid-count, then resume
    rst = 1'b0; load = 1'b1; en = 1'b0; load_value = 8'h5A;
    tick(); check_all("pre_rst");
    load = 1'b0; en = 1'b1; rst = 1'b1;
    tick(); check_all("mid_rst");
    rst = 1'b0;
    tick(); check_all("resume"); chk("resume_const", int'(binary_value), 1);

`ifdef GRAY_CNT_STEP_CHK_EN
    // corrupt the Gray register after an en step: 00 -> 03 is a 2-bit step
    rst = 1'b1; en = 1'b0;
    tick(); check_all("chk_rst");
    rst = 1'b0; en = 1'b1;
    tick();
    force dut.gray_q = 8'h03;
    en = 1'b0;
    tick(); chk("chk_err_set", int'(err), 1);
    release dut.gray_q;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("chk_err_sticky", int'(err), 1);
    end
    rst = 1'b1;
    tick(); check_all("chk_err_clr");
    rst = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
